sha3_squeeze: RTL and testbench

Squeeze-side output unit of the Keccak sponge: takes a permuted 1600-bit state and streams the digest or XOF output as 64-bit little-endian lanes with byte keeps. It requests further permutations when the rate is exhausted and more output is owed. It sits between the permutation core and the downstream consumer, mirroring the absorb/padding path.

---
 rtl/keccak_pkg.sv | 24 ++
 rtl/sha3_setup.sv | 27 ++
 rtl/sha3_squeeze.sv | 158 +++++++++++++++
 tb/tb_sha3_squeeze.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak definitions for the sponge datapath: mode encodings, widths
// and the squeeze-side FSM state type.
package keccak_pkg;

  localparam int MODE_SEL_WIDTH = 3;
  localparam int RATE_WIDTH     = 11;
  localparam int LANE_W         = 64;
  localparam int NUM_LANES      = 25;

  typedef enum logic [MODE_SEL_WIDTH-1:0] {
    SHA3_256 = 3'd0,
    SHA3_512 = 3'd1,
    SHAKE128 = 3'd2,
    SHAKE256 = 3'd3
  } keccak_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_STATE,
    EMIT,
    DONE
  } squeeze_state_e;

endpackage

// File: rtl/sha3_setup.sv
// Mode decoder: rate, capacity (bits) and domain-separation suffix for each
// supported Keccak mode. Unsupported encodings report a rate of zero.
module sha3_setup
  import keccak_pkg::*;
(
  input  logic [MODE_SEL_WIDTH-1:0] mode_i,
  output logic [RATE_WIDTH-1:0]     rate_o,
  output logic [RATE_WIDTH-1:0]     capacity_o,
  output logic [7:0]                suffix_o
);

  // Table lookup of sponge parameters for the selected mode.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    rate_o     = '0;
    capacity_o = '0;
    suffix_o   = '0;
    case (mode_i)
      SHA3_256: begin rate_o = 11'd1088; capacity_o = 11'd512;  suffix_o = 8'h06; end
      SHA3_512: begin rate_o = 11'd576;  capacity_o = 11'd1024; suffix_o = 8'h06; end
      SHAKE128: begin rate_o = 11'd1344; capacity_o = 11'd256;  suffix_o = 8'h1F; end
      SHAKE256: begin rate_o = 11'd1088; capacity_o = 11'd512;  suffix_o = 8'h1F; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/sha3_squeeze.sv
// Squeeze-side output unit of the Keccak sponge. Captures a permuted state,
// streams its rate lanes as 64-bit little-endian beats with byte keeps, and
// requests another permutation whenever the rate runs out before the
// requested output length has been delivered.
module sha3_squeeze
  import keccak_pkg::*;
#(
  parameter int DWIDTH  = 64,
  parameter int STATE_W = 1600,
  parameter int LEN_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [MODE_SEL_WIDTH-1:0] keccak_mode_i,
  input  logic [LEN_W-1:0]          out_len_i,
  input  logic [STATE_W-1:0]        state_i,
  input  logic                      state_valid_i,
  output logic                      state_ready_o,
  output logic                      perm_req_o,
  output logic [DWIDTH-1:0]         dout_o,
  output logic [DWIDTH/8-1:0]       dout_keep_o,
  output logic                      dout_valid_o,
  input  logic                      dout_ready_i,
  output logic                      dout_last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int KEEP_W = DWIDTH / 8;

  squeeze_state_e                     r_fsm;
  squeeze_state_e                     w_fsm_next;
  logic [MODE_SEL_WIDTH-1:0]          r_mode;
  logic [4:0]                         r_rate_lanes;
  logic [LEN_W-1:0]                   r_remaining;
  logic [4:0]                         r_lane_idx;
  logic [NUM_LANES-1:0][LANE_W-1:0]   r_lanes;

  logic [MODE_SEL_WIDTH-1:0]          w_setup_mode;
  logic [RATE_WIDTH-1:0]              w_rate;
  logic [RATE_WIDTH-1:0]              w_unused_capacity;
  logic [7:0]                         w_unused_suffix;
  logic [LEN_W-1:0]                   w_start_len;
  logic [LEN_W-1:0]                   w_take;
  logic [LEN_W-1:0]                   w_rem_next;
  logic                               w_start_ok;
  logic                               w_accept;
  logic                               w_fire;
  logic                               w_rate_end;

  // While idle the decoder looks at the incoming mode so an unsupported
  // start can be rejected; afterwards it follows the latched mode.
  assign w_setup_mode = (r_fsm == IDLE) ? keccak_mode_i : r_mode;

  sha3_setup u_setup (
    .mode_i     (w_setup_mode),
    .rate_o     (w_rate),
    .capacity_o (w_unused_capacity),
    .suffix_o   (w_unused_suffix)
  );

  assign w_start_ok = start_i && (r_fsm == IDLE) && (w_rate != '0);
  assign w_accept   = (r_fsm == WAIT_STATE) && state_valid_i;
  assign w_fire     = (r_fsm == EMIT) && dout_ready_i;
  assign w_take     = (r_remaining >= LEN_W'(8)) ? LEN_W'(8) : r_remaining;
  assign w_rem_next = r_remaining - w_take;
  assign w_rate_end = (r_lane_idx + 5'd1) == r_rate_lanes;

  // Fixed-length modes ignore the requested length.
  always_comb begin
    w_start_len = out_len_i;
    case (keccak_mode_i)
      SHA3_256: w_start_len = LEN_W'(32);
      SHA3_512: w_start_len = LEN_W'(64);
      default:  ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) r_fsm <= IDLE;
    else         r_fsm <= w_fsm_next;
  end

  // Next-state and output decode; output ending on the rate boundary
  // terminates without asking for another permutation.
  always_comb begin
    w_fsm_next    = r_fsm;
    state_ready_o = 1'b0;
    perm_req_o    = 1'b0;
    dout_o        = '0;
    dout_keep_o   = '0;
    dout_valid_o  = 1'b0;
    dout_last_o   = 1'b0;
    done_o        = 1'b0;
    busy_o        = (r_fsm != IDLE);
    case (r_fsm)
      IDLE: begin
        if (w_start_ok) w_fsm_next = (w_start_len == '0) ? DONE : WAIT_STATE;
      end
      WAIT_STATE: begin
        state_ready_o = 1'b1;
        if (state_valid_i) w_fsm_next = EMIT;
      end
      EMIT: begin
        dout_valid_o = 1'b1;
        dout_o       = r_lanes[r_lane_idx];
        dout_keep_o  = (r_remaining >= LEN_W'(8)) ? '1
                     : KEEP_W'((8'd1 << r_remaining[2:0]) - 8'd1);
        dout_last_o  = (r_remaining <= LEN_W'(8));
        if (dout_ready_i) begin
          if (w_rem_next == '0) begin
            w_fsm_next = DONE;
          end else if (w_rate_end) begin
            perm_req_o = 1'b1;
            w_fsm_next = WAIT_STATE;
          end
        end
      end
      DONE: begin
        done_o     = 1'b1;
        w_fsm_next = IDLE;
      end
      default: w_fsm_next = IDLE;
    endcase
  end

  // Datapath: latch mode/length on start, capture the state, count output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode       <= '0;
      r_rate_lanes <= '0;
      r_remaining  <= '0;
      r_lane_idx   <= '0;
      // NOTE: the captured state is cleared too, so dout_o cannot leak a
      // previous digest after reset.
      r_lanes      <= '0;
    end else begin
      if (w_start_ok) begin
        r_mode       <= keccak_mode_i;
        r_rate_lanes <= 5'(w_rate >> 6);
        r_remaining  <= w_start_len;
      end
      if (w_accept) begin
        r_lanes    <= state_i;
        r_lane_idx <= '0;
      end
      if (w_fire) begin
        r_remaining <= w_rem_next;
        r_lane_idx  <= w_rate_end ? 5'd0 : r_lane_idx + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha3_squeeze.sv
// Directed bench for sha3_squeeze: expected beats are queued from a small
// byte-count model when a state is offered and popped on each handshake.
module tb_sha3_squeeze;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    mode;
  logic [15:0]   out_len;
  logic [1599:0] st;
  logic          st_valid;
  logic          st_ready;
  logic          perm_req;
  logic [63:0]   dout;
  logic [7:0]    keep;
  logic          dvalid;
  logic          dready;
  logic          dlast;
  logic          busy;
  logic          done;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  sha3_squeeze dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .keccak_mode_i (mode),
    .out_len_i     (out_len),
    .state_i       (st),
    .state_valid_i (st_valid),
    .state_ready_o (st_ready),
    .perm_req_o    (perm_req),
    .dout_o        (dout),
    .dout_keep_o   (keep),
    .dout_valid_o  (dvalid),
    .dout_ready_i  (dready),
    .dout_last_o   (dlast),
    .busy_o        (busy),
    .done_o        (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1599:0] make_state(input logic [31:0] seed);
    logic [1599:0] s;
    for (int i = 0; i < 25; i++) s[64*i +: 64] = {seed, 32'(i)};
    return s;
  endfunction

  // Queue the beats one state yields: lanes from 0 until the bytes or the
  // rate run out. Returns the bytes still owed afterwards.
  task automatic expect_block(input logic [1599:0] s, input int bytes, input int rate,
                              output int left);
    left = bytes;
    for (int i = 0; i < rate && left > 0; i++) begin
      beat_t b;
      b.data = s[64*i +: 64];
      b.keep = (left >= 8) ? 8'hFF : 8'((1 << left) - 1);
      left   = left - ((left >= 8) ? 8 : left);
      b.last = (left == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic do_start(input logic [2:0] m, input logic [15:0] len);
    @(negedge clk);
    mode = m; out_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic give_state(input logic [1599:0] s);
    int k = 0;
    while (!st_ready && k < 20) begin
      @(negedge clk); #1; k++;
    end
    check("state_ready_wait", 64'(st_ready), 64'd1);
    st = s; st_valid = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    check("first_valid", 64'(dvalid), 64'd1);
  endtask

  // Drain the queue; ready is either held high or toggled 1,0,1,0...
  task automatic stream(input bit toggle, input bit exp_perm);
    int cyc = 0;
    bit rdy = 1'b1;
    while (exp_q.size() > 0 && cyc < 200) begin
      dready = rdy;
      #1;
      if (dvalid && dready) begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_data", dout, b.data);
        check("beat_keep", 64'(keep), 64'(b.keep));
        check("beat_last", 64'(dlast), 64'(b.last));
        check("perm_req", 64'(perm_req), 64'(exp_perm && exp_q.size() == 0));
      end else if (dvalid) begin
        check("stall_data", dout, exp_q[0].data);
        check("stall_last", 64'(dlast), 64'(exp_q[0].last));
      end else begin
        check("valid_dropped", 64'(dvalid), 64'd1);
      end
      @(negedge clk);
      #1;
      cyc++;
      rdy = toggle ? ~rdy : 1'b1;
    end
    dready = 1'b0;
    check("stream_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic expect_done();
    check("done_pulse", 64'(done), 64'd1);
    check("no_ready_in_done", 64'(st_ready), 64'd0);
    @(negedge clk); #1;
    check("done_clear", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1599:0] s1;
    logic [1599:0] s2;
    int left;

    rst_n = 1'b0; start = 1'b0; mode = '0; out_len = '0;
    st = '0; st_valid = 1'b0; dready = 1'b0;
    #12;
    check("rst_valid", 64'(dvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(st_ready), 64'd0);
    check("rst_dout", dout, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // SHA3_256: 4 full beats, no permutation request.
    s1 = make_state(32'h1111_0000);
    s1[63:0] = 64'h0123456789ABCDEF; s1[127:64] = 64'd1;
    s1[191:128] = 64'd2; s1[255:192] = 64'd3;
    do_start(3'd0, 16'd999);
    check("sha256_ready_next", 64'(st_ready), 64'd1);
    give_state(s1);
    expect_block(s1, 32, 17, left);
    stream(1'b0, 1'b0);
    expect_done();

    // SHA3_512 with ready toggling: 8 beats, held stable while stalled.
    s1 = make_state(32'h5120_0000);
    do_start(3'd1, 16'd0);
    give_state(s1);
    expect_block(s1, 64, 9, left);
    stream(1'b1, 1'b0);
    expect_done();

    // SHAKE128 173 bytes: 21 beats, permutation, then one 5-byte beat.
    s1 = make_state(32'h1280_00AA);
    s2 = make_state(32'h1280_00BB);
    do_start(3'd2, 16'd173);
    give_state(s1);
    expect_block(s1, 173, 21, left);
    check("shake128_left", 64'(left), 64'd5);
    stream(1'b0, 1'b1);
    check("rewait_ready", 64'(st_ready), 64'd1);
    check("rewait_done", 64'(done), 64'd0);
    give_state(s2);
    expect_block(s2, left, 21, left);
    stream(1'b0, 1'b0);
    expect_done();

    // SHAKE256 136 bytes: ends exactly on the rate boundary.
    s1 = make_state(32'h2560_0000);
    do_start(3'd3, 16'd136);
    give_state(s1);
    expect_block(s1, 136, 17, left);
    stream(1'b0, 1'b0);
    expect_done();

    // Zero-length SHAKE goes straight to DONE.
    do_start(3'd2, 16'd0);
    check("zero_no_ready", 64'(st_ready), 64'd0);
    check("zero_no_valid", 64'(dvalid), 64'd0);
    expect_done();

    // Unsupported mode is ignored.
    do_start(3'd6, 16'd8);
    check("badmode_busy", 64'(busy), 64'd0);
    check("badmode_ready", 64'(st_ready), 64'd0);

    // start while busy does not disturb the latched SHA3_256 job.
    s1 = make_state(32'hB05B_0000);
    do_start(3'd0, 16'd0);
    check("busy_set", 64'(busy), 64'd1);
    do_start(3'd2, 16'd3);
    check("busy_held", 64'(busy), 64'd1);
    check("busy_ready_held", 64'(st_ready), 64'd1);
    give_state(s1);
    expect_block(s1, 32, 17, left);
    stream(1'b0, 1'b0);
    expect_done();

    // Reset in the middle of EMIT clears everything at once.
    s1 = make_state(32'hDEAD_0000);
    do_start(3'd1, 16'd0);
    give_state(s1);
    dready = 1'b1;
    @(negedge clk); #1;
    check("mid_emit_valid", 64'(dvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(dvalid), 64'd0);
    check("arst_dout", dout, 64'd0);
    check("arst_keep", 64'(keep), 64'd0);
    check("arst_last", 64'(dlast), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_perm", 64'(perm_req), 64'd0);
    dready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Short SHAKE256 after reset: full beat then a 3-byte partial beat.
    s1 = make_state(32'h0B0B_0000);
    do_start(3'd3, 16'd11);
    give_state(s1);
    expect_block(s1, 11, 17, left);
    stream(1'b0, 1'b0);
    expect_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
